mem_store_ctrl: RTL and testbench
=================================

MEM_STORE_CTRL -- requirements
Module: mem_store_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have parameter MEM_TYPE_LEN, default from constants.vh, width of store-type code.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  store request present.
REQ-006 SHALL have port req_ready  output  1  controller accepts request this cycle.
REQ-007 SHALL have port req_addr  input  XLEN  byte address of store.
REQ-008 SHALL have port req_data  input  XLEN  register data, value in low bits.
REQ-009 SHALL have port req_type  input  MEM_TYPE_LEN  MEM_B / MEM_H / MEM_W code from constants.vh.
REQ-010 SHALL have port bus_req  output  1  data-memory write request.
REQ-011 SHALL have port bus_addr  output  XLEN  word-aligned write address, bits [1:0] always 0.
REQ-012 SHALL have port bus_wdata  output  XLEN  lane-positioned write data.
REQ-013 SHALL have port bus_wstrb  output  4  byte-lane write enables.
REQ-014 SHALL have port bus_ack  input  1  memory completed current write.
REQ-015 SHALL have port done  output  1  one-cycle pulse, store fully written.
REQ-016 SHALL have port busy  output  1  transaction in progress (not IDLE).

Function
REQ-017 SHALL implement states IDLE, BEAT0, BEAT1.
REQ-018 req_ready SHALL be 1 exactly when state is IDLE; handshake = req_valid & req_ready.
REQ-019 On handshake, SHALL register address, type and data; bus_req rises next cycle (state BEAT0).
REQ-020 Size: MEM_B = 1 byte, MEM_H = 2 bytes, MEM_W and any other code = 4 bytes; unused high data bits masked to 0.
REQ-021 With off = addr[1:0]: 8-bit mask = ((1<<size)-1) << off; 64-bit data = masked data << (8*off).
REQ-022 BEAT0 SHALL drive bus_addr = {addr[31:2],2'b00}, bus_wstrb = mask[3:0], bus_wdata = data[31:0].
REQ-023 If mask[7:4] != 0 (split), BEAT1 SHALL drive bus_addr = BEAT0 address + 4 (mod 2^32), bus_wstrb = mask[7:4], bus_wdata = data[63:32].
REQ-024 bus_req, bus_addr, bus_wdata, bus_wstrb SHALL remain stable while bus_req = 1 and bus_ack = 0.
REQ-025 bus_ack in BEAT0: split -> BEAT1 (bus_req stays 1); else -> IDLE, bus_req 0.
REQ-026 bus_ack in BEAT1 -> IDLE, bus_req 0.
REQ-027 done SHALL be 1 in the single cycle after the final ack, else 0.
REQ-028 A request presented in the done cycle SHALL be accepted (no bubble).
REQ-029 bus_ack while bus_req = 0 SHALL be ignored.
REQ-030 All outputs SHALL be registered; unrequested lanes in bus_wdata SHALL be 0.

Reset
REQ-031 reset SHALL force, without waiting for clk: state IDLE, bus_req 0, bus_addr 0, bus_wdata 0, bus_wstrb 0, done 0, busy 0, req_ready 1.
REQ-032 Reset mid-transaction SHALL abandon it: no further beat, no done pulse.

Verification
REQ-033 MEM_B addr 0x103 data 0xAABBCCDD -> one beat: 0x100, wdata 0xDD000000, wstrb 1000; done after ack.
REQ-034 MEM_H addr 0x103 data 0x00001234 -> beat0 0x100/0x34000000/1000, beat1 0x104/0x00000012/0001; done only after second ack.
REQ-035 MEM_W addr 0x200 data 0xDEADBEEF, ack delayed 3 cycles -> bus signals stable, req_ready 0 throughout; done one cycle after ack.
REQ-036 MEM_W addr 0xFFFFFFFE data 0x11223344 -> beat0 0xFFFFFFFC/0x33440000/1100, beat1 0x00000000/0x00001122/0011.
REQ-037 Reset during BEAT1 wait -> bus_req 0 immediately, no done; req_ready 1 after release.
REQ-038 New MEM_B request held valid in done cycle -> accepted that cycle; bus_req rises next cycle.

Source files
------------

// File: rtl/mem_store_ctrl_if.sv
// Store-request channel plus data-memory write channel for mem_store_ctrl.
// master: the store controller (accepts requests, drives the memory bus).
// slave:  the environment (issues requests, acknowledges memory writes).
interface mem_store_ctrl_if #(
    parameter int XLEN         = 32,
    parameter int MEM_TYPE_LEN = 2
);
    // request side
    logic                    req_valid;
    logic                    req_ready;
    logic [XLEN-1:0]         req_addr;
    logic [XLEN-1:0]         req_data;
    logic [MEM_TYPE_LEN-1:0] req_type;

    // memory write side
    logic                    bus_req;
    logic [XLEN-1:0]         bus_addr;
    logic [XLEN-1:0]         bus_wdata;
    logic [3:0]              bus_wstrb;
    logic                    bus_ack;

    // status
    logic                    done;
    logic                    busy;

    modport master (
        input  req_valid, req_addr, req_data, req_type, bus_ack,
        output req_ready, bus_req, bus_addr, bus_wdata, bus_wstrb, done, busy
    );

    modport slave (
        output req_valid, req_addr, req_data, req_type, bus_ack,
        input  req_ready, bus_req, bus_addr, bus_wdata, bus_wstrb, done, busy
    );
endinterface

// File: rtl/mem_store_ctrl.sv
// Byte/half/word store controller: aligns data to byte lanes, splits stores crossing a word into two beats.
// Latency: bus_req one cycle after accept; done one cycle after the final bus_ack.
// Backpressure: req_ready only in IDLE; bus outputs hold until bus_ack.
// Ports: clk, reset (async, active-high), io (mem_store_ctrl_if.master: req_*, bus_*, done, busy).
module mem_store_ctrl #(
    parameter int                    XLEN         = 32,   // only 32 supported
    parameter int                    MEM_TYPE_LEN = 2,
    parameter logic [MEM_TYPE_LEN-1:0] MEM_B      = MEM_TYPE_LEN'(0),
    parameter logic [MEM_TYPE_LEN-1:0] MEM_H      = MEM_TYPE_LEN'(1),
    parameter logic [MEM_TYPE_LEN-1:0] MEM_W      = MEM_TYPE_LEN'(2)
) (
    input  logic              clk,
    input  logic              reset,
    mem_store_ctrl_if.master  io
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Second-beat payload, captured at accept time so BEAT1 needs no arithmetic.
    logic [XLEN-1:0] hi_addr_q, hi_addr_d;
    logic [XLEN-1:0] hi_wdata_q, hi_wdata_d;
    logic [3:0]      hi_wstrb_q, hi_wstrb_d;

    logic            bus_req_d;
    logic [XLEN-1:0] bus_addr_d;
    logic [XLEN-1:0] bus_wdata_d;
    logic [3:0]      bus_wstrb_d;
    logic            done_d;
    logic            req_ready_d;
    logic            busy_d;

    // Lane alignment of the incoming request
    logic [1:0]      off;
    logic [3:0]      size_mask;
    logic [XLEN-1:0] masked_data;
    logic [7:0]      mask8;
    logic [63:0]     data64;
    logic [XLEN-1:0] lo_addr;
    logic            handshake;

    assign off       = io.req_addr[1:0];
    assign lo_addr   = {io.req_addr[XLEN-1:2], 2'b00};
    assign handshake = io.req_valid && io.req_ready;

    always_comb begin
        size_mask   = 4'b1111;
        masked_data = io.req_data;
        case (io.req_type)
            MEM_B: begin
                size_mask   = 4'b0001;
                masked_data = {24'd0, io.req_data[7:0]};
            end
            MEM_H: begin
                size_mask   = 4'b0011;
                masked_data = {16'd0, io.req_data[15:0]};
            end
            MEM_W: begin
                size_mask   = 4'b1111;
                masked_data = io.req_data;
            end
            default: begin
                // unknown codes store a full word
                size_mask   = 4'b1111;
                masked_data = io.req_data;
            end
        endcase
        // Upper nibble of mask8 / upper word of data64 belong to the next word.
        mask8  = {4'd0, size_mask} << off;
        data64 = {32'd0, masked_data} << {off, 3'b000};
    end

    always_comb begin
        state_d     = state_q;
        hi_addr_d   = hi_addr_q;
        hi_wdata_d  = hi_wdata_q;
        hi_wstrb_d  = hi_wstrb_q;
        bus_req_d   = io.bus_req;
        bus_addr_d  = io.bus_addr;
        bus_wdata_d = io.bus_wdata;
        bus_wstrb_d = io.bus_wstrb;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d     = BEAT0;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = lo_addr;
                    bus_wdata_d = data64[31:0];
                    bus_wstrb_d = mask8[3:0];
                    hi_addr_d   = lo_addr + XLEN'(4);   // wraps at 2^32
                    hi_wdata_d  = data64[63:32];
                    hi_wstrb_d  = mask8[7:4];
                end
            end
            BEAT0: begin
                if (io.bus_ack) begin
                    if (hi_wstrb_q != 4'd0) begin
                        // split store: bus_req stays high into the second beat
                        state_d     = BEAT1;
                        bus_addr_d  = hi_addr_q;
                        bus_wdata_d = hi_wdata_q;
                        bus_wstrb_d = hi_wstrb_q;
                    end else begin
                        state_d   = IDLE;
                        bus_req_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (io.bus_ack) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase

        // Registered from the next state so they line up with state_q.
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hi_addr_q    <= '0;
            hi_wdata_q   <= '0;
            hi_wstrb_q   <= '0;
            io.bus_req   <= 1'b0;
            io.bus_addr  <= '0;
            io.bus_wdata <= '0;
            io.bus_wstrb <= '0;
            io.done      <= 1'b0;
            io.busy      <= 1'b0;
            io.req_ready <= 1'b1;
        end else begin
            state_q      <= state_d;
            hi_addr_q    <= hi_addr_d;
            hi_wdata_q   <= hi_wdata_d;
            hi_wstrb_q   <= hi_wstrb_d;
            io.bus_req   <= bus_req_d;
            io.bus_addr  <= bus_addr_d;
            io.bus_wdata <= bus_wdata_d;
            io.bus_wstrb <= bus_wstrb_d;
            io.done      <= done_d;
            io.busy      <= busy_d;
            io.req_ready <= req_ready_d;
        end
    end

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Bench for mem_store_ctrl: byte-lane model feeds an expected-beat queue that
// is drained against the memory bus as the bench acknowledges each beat.
module tb_mem_store_ctrl;

    localparam logic [1:0] T_B = 2'd0;
    localparam logic [1:0] T_H = 2'd1;
    localparam logic [1:0] T_W = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } beat_t;

    logic  clk = 1'b0;
    logic  reset;
    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];

    mem_store_ctrl_if #(.XLEN(32), .MEM_TYPE_LEN(2)) io();

    mem_store_ctrl #(.XLEN(32), .MEM_TYPE_LEN(2)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.master)
    );

    always #5 clk = ~clk;

    // Byte-by-byte placement model: byte i of the value lands in lane off+i,
    // lanes 4..7 belong to the following word.
    function automatic void model_push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        int          size;
        int          lane;
        logic [7:0]  strb8;
        logic [63:0] w;
        logic [31:0] base;
        beat_t       b;
        size  = (t == T_B) ? 1 : (t == T_H) ? 2 : 4;
        strb8 = '0;
        w     = '0;
        for (int i = 0; i < size; i++) begin
            lane              = int'(a[1:0]) + i;
            strb8[lane]       = 1'b1;
            w[lane*8 +: 8]    = d[i*8 +: 8];
        end
        base = a & 32'hFFFF_FFFC;
        b = '{addr: base, wdata: w[31:0], strb: strb8[3:0]};
        exp_q.push_back(b);
        if (strb8[7:4] != 4'd0) begin
            b = '{addr: base + 32'd4, wdata: w[63:32], strb: strb8[7:4]};
            exp_q.push_back(b);
        end
    endfunction

    function automatic beat_t bus_now();
        beat_t b;
        b = '{addr: io.bus_addr, wdata: io.bus_wdata, strb: io.bus_wstrb};
        return b;
    endfunction

    // Present a request from a negedge until accepted; returns at the negedge after accept.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        int n;
        n            = 0;
        io.req_valid = 1'b1;
        io.req_addr  = a;
        io.req_data  = d;
        io.req_type  = t;
        while (io.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (io.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_ready: req_ready=%b want 1", io.req_ready);
        end
        @(posedge clk);
        #1;
        io.req_valid = 1'b0;
        @(negedge clk);
    endtask

    // Drain the expected queue: hold ack low for 'delay' cycles per beat, then ack.
    // Returns at the negedge of the done cycle.
    task automatic serve(input string tag, input int delay);
        beat_t e;
        beat_t cur;
        int    n;
        bit    first;
        first = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = 0;
            while (io.bus_req !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (io.bus_req !== 1'b1 || (!first && n != 0)) begin
                bad++;
                $display("FAIL %s bus_req: got %b after %0d cycles, want 1 immediately", tag, io.bus_req, n);
                exp_q.delete();
                return;
            end
            cur = bus_now();
            total++;
            if (cur !== e) begin
                bad++;
                $display("FAIL %s beat: got addr=%h wdata=%h strb=%b want addr=%h wdata=%h strb=%b",
                         tag, cur.addr, cur.wdata, cur.strb, e.addr, e.wdata, e.strb);
            end
            total++;
            if (io.done !== 1'b0 || io.req_ready !== 1'b0 || io.busy !== 1'b1) begin
                bad++;
                $display("FAIL %s status_mid: done=%b ready=%b busy=%b want 0 0 1", tag, io.done, io.req_ready, io.busy);
            end
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                cur = bus_now();
                total++;
                if (cur !== e || io.bus_req !== 1'b1 || io.req_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s hold: got addr=%h wdata=%h strb=%b req=%b ready=%b want addr=%h wdata=%h strb=%b req=1 ready=0",
                             tag, cur.addr, cur.wdata, cur.strb, io.bus_req, io.req_ready, e.addr, e.wdata, e.strb);
                end
            end
            io.bus_ack = 1'b1;
            @(posedge clk);
            #1;
            io.bus_ack = 1'b0;
            @(negedge clk);
            first = 1'b0;
        end
        total++;
        if (io.done !== 1'b1 || io.bus_req !== 1'b0 || io.busy !== 1'b0 || io.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s finish: done=%b req=%b busy=%b ready=%b want 1 0 0 1",
                     tag, io.done, io.bus_req, io.busy, io.req_ready);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        io.req_valid = 1'b0;
        io.req_addr  = '0;
        io.req_data  = '0;
        io.req_type  = T_W;
        io.bus_ack   = 1'b0;
        #1;
        total++;
        if (io.bus_req !== 1'b0 || io.bus_addr !== 32'd0 || io.bus_wdata !== 32'd0 || io.bus_wstrb !== 4'd0 ||
            io.done !== 1'b0 || io.busy !== 1'b0 || io.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: req=%b addr=%h wdata=%h strb=%b done=%b busy=%b ready=%b want 0 0 0 0 0 0 1",
                     io.bus_req, io.bus_addr, io.bus_wdata, io.bus_wstrb, io.done, io.busy, io.req_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        // stray ack with no request outstanding must do nothing
        io.bus_ack = 1'b1;
        repeat (2) @(negedge clk);
        io.bus_ack = 1'b0;
        @(negedge clk);
        total++;
        if (io.bus_req !== 1'b0 || io.done !== 1'b0 || io.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_ack: req=%b done=%b ready=%b want 0 0 1", io.bus_req, io.done, io.req_ready);
        end
    endtask

    task automatic test_byte_single();
        model_push(32'h0000_0103, 32'hAABB_CCDD, T_B);
        issue(32'h0000_0103, 32'hAABB_CCDD, T_B);
        total++;
        if (io.bus_req !== 1'b1 || io.bus_wdata !== 32'hDD00_0000 || io.bus_wstrb !== 4'b1000) begin
            bad++;
            $display("FAIL byte_latency: req=%b wdata=%h strb=%b want 1 dd000000 1000", io.bus_req, io.bus_wdata, io.bus_wstrb);
        end
        serve("byte", 1);
        @(negedge clk);
        total++;
        if (io.done !== 1'b0) begin
            bad++;
            $display("FAIL byte_done_pulse: done=%b want 0", io.done);
        end
    endtask

    task automatic test_half_split();
        model_push(32'h0000_0103, 32'h0000_1234, T_H);
        issue(32'h0000_0103, 32'h0000_1234, T_H);
        serve("half_split", 0);
        @(negedge clk);
    endtask

    task automatic test_word_delayed();
        model_push(32'h0000_0200, 32'hDEAD_BEEF, T_W);
        issue(32'h0000_0200, 32'hDEAD_BEEF, T_W);
        serve("word_delay", 3);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        model_push(32'hFFFF_FFFE, 32'h1122_3344, T_W);
        issue(32'hFFFF_FFFE, 32'h1122_3344, T_W);
        total++;
        if (io.bus_addr !== 32'hFFFF_FFFC || io.bus_wdata !== 32'h3344_0000 || io.bus_wstrb !== 4'b1100) begin
            bad++;
            $display("FAIL wrap_beat0: addr=%h wdata=%h strb=%b want fffffffc 33440000 1100", io.bus_addr, io.bus_wdata, io.bus_wstrb);
        end
        serve("wrap", 1);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        beat_t e;
        beat_t cur;
        model_push(32'h0000_0103, 32'h0000_1234, T_H);
        issue(32'h0000_0103, 32'h0000_1234, T_H);
        e   = exp_q.pop_front();
        cur = bus_now();
        total++;
        if (cur !== e) begin
            bad++;
            $display("FAIL rst_mid_beat0: got %h/%h/%b want %h/%h/%b", cur.addr, cur.wdata, cur.strb, e.addr, e.wdata, e.strb);
        end
        io.bus_ack = 1'b1;
        @(posedge clk);
        #1;
        io.bus_ack = 1'b0;
        @(negedge clk);
        e   = exp_q.pop_front();
        cur = bus_now();
        total++;
        if (cur !== e || io.bus_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_beat1: got %h/%h/%b req=%b want %h/%h/%b req=1",
                     cur.addr, cur.wdata, cur.strb, io.bus_req, e.addr, e.wdata, e.strb);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (io.bus_req !== 1'b0 || io.req_ready !== 1'b1 || io.busy !== 1'b0 || io.bus_wstrb !== 4'd0 || io.bus_addr !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_async: req=%b ready=%b busy=%b strb=%b addr=%h want 0 1 0 0000 0",
                     io.bus_req, io.req_ready, io.busy, io.bus_wstrb, io.bus_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (io.done !== 1'b0 || io.bus_req !== 1'b0 || io.req_ready !== 1'b1) begin
                bad++;
                $display("FAIL rst_mid_after: cycle %0d done=%b req=%b ready=%b want 0 0 1", i, io.done, io.bus_req, io.req_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        model_push(32'h0000_0010, 32'h0000_0055, T_B);
        issue(32'h0000_0010, 32'h0000_0055, T_B);
        serve("b2b_first", 0);
        // still in the done cycle: the next request must be taken now
        model_push(32'h0000_0021, 32'h0000_00A7, T_B);
        issue(32'h0000_0021, 32'h0000_00A7, T_B);
        total++;
        if (io.bus_req !== 1'b1 || io.done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: req=%b done=%b want 1 0", io.bus_req, io.done);
        end
        serve("b2b_second", 0);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  t;
        for (int k = 0; k < 16; k++) begin
            a = $urandom;
            d = $urandom;
            t = 2'($urandom_range(0, 3));
            model_push(a, d, t);
            issue(a, d, t);
            serve("random", $urandom_range(0, 2));
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_byte_single();
        test_half_split();
        test_word_delayed();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
